// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus enable arbiter.
//  - arb_state_t : arbiter FSM states
//  - MAX_REQ     : widest requester vector supported (bounds onehot_check)
//  - TURN_CNT_W  : turnaround counter width, enough for TURN_CYCLES up to 7
//  - cnt_w()     : bits needed to hold a count of 0..max_val
//  - onehot_check(): true when at most one bit of the vector is set
package bus_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      TURN  = 2'd2
   } arb_state_t;

   localparam int MAX_REQ    = 8;
   localparam int TURN_CNT_W = 3;

   function automatic int cnt_w(input int max_val);
      return $clog2(max_val + 1);
   endfunction

   function automatic logic onehot_check(input logic [MAX_REQ-1:0] v);
      return (v & (v - MAX_REQ'(1))) == '0;
   endfunction

endpackage

// File: rtl/bus_enable_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search.
// Finds the first set req bit at or after ptr_i, wrapping N_REQ-1 -> 0.
// Ports:
//  req_i     in  N_REQ   request vector
//  ptr_i     in  IDX_W   round-robin start position
//  winner_o  out IDX_W   index of the chosen requester (0 when none)
//  any_req_o out 1       at least one request present
module rr_pick #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req_i,
   input  logic [$clog2(N_REQ)-1:0] ptr_i,
   output logic [$clog2(N_REQ)-1:0] winner_o,
   output logic                     any_req_o
);
   localparam int IDX_W = $clog2(N_REQ);

   // The request vector is duplicated and the lower copy is masked below
   // ptr; the lowest remaining set bit is the winner, and the upper copy
   // supplies the wrapped-around candidates.
   logic [2*N_REQ-1:0] mask;
   logic [2*N_REQ-1:0] dbl;

   always_comb begin
      mask = '0;
      for (int i = 0; i < 2*N_REQ; i++)
         mask[i] = (i >= int'(ptr_i));
      dbl      = {req_i, req_i} & mask;
      winner_o = '0;
      for (int i = 2*N_REQ-1; i >= 0; i--)
         if (dbl[i]) winner_o = IDX_W'(i % N_REQ);
   end

   assign any_req_o = |req_i;

endmodule

// File: rtl/bus_enable_arbiter.sv
// bus_enable_arbiter: round-robin owner selection for a shared tri-state bus.
// Drives active-low buffer-group enables, at most one low at a time, with
// TURN_CYCLES all-high dead cycles after every release so two groups never
// drive the bus together. All outputs are flops.
// Optional feature macro: BUS_ARB_TIMEOUT_EN (revoke a grant after MAX_HOLD
// cycles when someone else is waiting; pulses timeout).
// Ports:
//  clk      in   1        rising-edge clock
//  rst      in   1        asynchronous active-high reset
//  req      in   N_REQ    level requests, held until finished
//  g_n      out  N_REQ    active-low buffer enables
//  grant    out  N_REQ    one-hot grant, equal to ~g_n
//  owner    out  IDX_W    current owner index, valid while busy
//  busy     out  1        in GRANT state
//  timeout  out  1        1-cycle pulse when a grant is revoked by MAX_HOLD
module bus_enable_arbiter
   import bus_arb_pkg::*;
#(
   parameter int N_REQ       = 4,
   parameter int TURN_CYCLES = 1,
   parameter int MAX_HOLD    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req,
   output logic [N_REQ-1:0]         g_n,
   output logic [N_REQ-1:0]         grant,
   output logic [$clog2(N_REQ)-1:0] owner,
   output logic                     busy,
   output logic                     timeout
);
   localparam int IDX_W = $clog2(N_REQ);

   if (N_REQ < 2 || N_REQ > MAX_REQ) begin : g_bad_nreq
      $error("N_REQ out of range");
   end
   if (TURN_CYCLES < 1 || TURN_CYCLES > 7) begin : g_bad_turn
      $error("TURN_CYCLES out of range");
   end
   if (MAX_HOLD < 1) begin : g_bad_hold
      $error("MAX_HOLD out of range");
   end

   arb_state_t            state_q;
   logic [IDX_W-1:0]      ptr_q;
   logic [IDX_W-1:0]      owner_q;
   logic [N_REQ-1:0]      grant_q;
   logic [N_REQ-1:0]      g_n_q;
   logic [TURN_CNT_W-1:0] turn_q;
   logic                  busy_q;
   logic                  timeout_q;

   logic [IDX_W-1:0]      winner;
   logic                  any_req;
   logic [N_REQ-1:0]      grant_d;
   logic [IDX_W-1:0]      ptr_d;
   logic                  rel_d;
   logic                  tmo_d;

   rr_pick #(.N_REQ(N_REQ)) u_pick (
      .req_i     (req),
      .ptr_i     (ptr_q),
      .winner_o  (winner),
      .any_req_o (any_req)
   );

   always_comb begin
      grant_d         = '0;
      grant_d[winner] = 1'b1;
   end

   assign rel_d = ~req[owner_q];
   assign ptr_d = (owner_q == IDX_W'(N_REQ-1)) ? '0 : owner_q + 1'b1;

`ifdef BUS_ARB_TIMEOUT_EN
   localparam int HOLD_W = cnt_w(MAX_HOLD);
   logic [HOLD_W-1:0] hold_q;
   // Revocation only applies to an owner still requesting; a voluntary
   // release in the same cycle is a normal release with no pulse.
   assign tmo_d = req[owner_q] && (hold_q == HOLD_W'(MAX_HOLD)) && |(req & ~grant_q);
`else
   assign tmo_d = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         owner_q   <= '0;
         grant_q   <= '0;
         g_n_q     <= '1;
         turn_q    <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
         hold_q    <= '0;
`endif
      end else begin
         timeout_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  state_q <= GRANT;
                  grant_q <= grant_d;
                  g_n_q   <= ~grant_d;
                  owner_q <= winner;
                  busy_q  <= 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
                  hold_q  <= HOLD_W'(1);
`endif
               end
            end
            GRANT: begin
               if (rel_d || tmo_d) begin
                  // Pointer moves past the owner on release and on revoke,
                  // so an owner that re-requests queues behind the others.
                  state_q   <= TURN;
                  grant_q   <= '0;
                  g_n_q     <= '1;
                  busy_q    <= 1'b0;
                  ptr_q     <= ptr_d;
                  turn_q    <= '0;
                  timeout_q <= tmo_d;
               end
`ifdef BUS_ARB_TIMEOUT_EN
               else if (hold_q != HOLD_W'(MAX_HOLD)) begin
                  hold_q <= hold_q + 1'b1;
               end
`endif
            end
            TURN: begin
               if (turn_q == TURN_CNT_W'(TURN_CYCLES-1)) begin
                  state_q <= IDLE;
                  turn_q  <= '0;
               end else begin
                  turn_q  <= turn_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign g_n     = g_n_q;
   assign grant   = grant_q;
   assign owner   = owner_q;
   assign busy    = busy_q;
   assign timeout = timeout_q;

   a_onehot: assert property (@(posedge clk) disable iff (rst)
      onehot_check(MAX_REQ'(grant_q)));
   a_gn_mirror: assert property (@(posedge clk) disable iff (rst)
      g_n_q == ~grant_q);
   a_idle_high: assert property (@(posedge clk) disable iff (rst)
      (state_q != GRANT) |-> (g_n_q == '1));

endmodule

// File: tb/tb_bus_enable_arbiter.sv
module tb_bus_enable_arbiter;
   localparam int N  = 4;
   localparam int TC = 1;
   localparam int MH = 8;
`ifdef BUS_ARB_TIMEOUT_EN
   localparam bit TMO_ON = 1'b1;
`else
   localparam bit TMO_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] req = '0;
   logic [3:0] g_n;
   logic [3:0] grant;
   logic [1:0] owner;
   logic       busy;
   logic       timeout;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bus_enable_arbiter #(.N_REQ(N), .TURN_CYCLES(TC), .MAX_HOLD(MH)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .g_n     (g_n),
      .grant   (grant),
      .owner   (owner),
      .busy    (busy),
      .timeout (timeout)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req = '0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({g_n, grant, busy, timeout, owner} !== {4'b1111, 4'b0000, 1'b0, 1'b0, 2'd0}) begin
         bad++;
         $display("FAIL reset_state: got g_n=%b grant=%b busy=%b tmo=%b owner=%0d want 1111/0000/0/0/0",
                  g_n, grant, busy, timeout, owner);
      end
      req = 4'b0010;
      tick();
      total++;
      if (grant !== 4'b0010) begin
         bad++; $display("FAIL reset_pregrant: got grant=%b want 0010", grant);
      end
      // async reset well away from any edge
      #2 rst = 1'b1;
      #1;
      total++;
      if ({g_n, grant, busy} !== {4'b1111, 4'b0000, 1'b0}) begin
         bad++;
         $display("FAIL reset_async: got g_n=%b grant=%b busy=%b want 1111/0000/0", g_n, grant, busy);
      end
      req = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      req = 4'b0100;
      tick();
      total++;
      if ({g_n, grant, busy, owner} !== {4'b1011, 4'b0100, 1'b1, 2'd2}) begin
         bad++;
         $display("FAIL single_grant: got g_n=%b grant=%b busy=%b owner=%0d want 1011/0100/1/2",
                  g_n, grant, busy, owner);
      end
      tick();
      total++;
      if (g_n !== 4'b1011) begin
         bad++; $display("FAIL single_hold: got g_n=%b want 1011", g_n);
      end
      req = '0;
      tick();
      total++;
      if ({g_n, busy} !== {4'b1111, 1'b0}) begin
         bad++; $display("FAIL single_turn: got g_n=%b busy=%b want 1111/0", g_n, busy);
      end
      tick();
      total++;
      if ({g_n, busy} !== {4'b1111, 1'b0}) begin
         bad++; $display("FAIL single_idle: got g_n=%b busy=%b want 1111/0", g_n, busy);
      end
      // lone requester regains the bus; ptr sits at 3 so the search wraps
      req = 4'b0100;
      tick();
      total++;
      if ({g_n, owner} !== {4'b1011, 2'd2}) begin
         bad++; $display("FAIL single_regain: got g_n=%b owner=%0d want 1011/2", g_n, owner);
      end
      req = '0;
      tick();
      tick();
   endtask

   task automatic test_all_four();
      int         order[5] = '{0, 1, 2, 3, 0};
      logic [3:0] oh;
      do_reset();
      req = 4'b1111;
      tick();
      for (int k = 0; k < 5; k++) begin
         oh = 4'b0001 << order[k];
         total++;
         if ({grant, g_n, owner} !== {oh, ~oh, 2'(order[k])}) begin
            bad++;
            $display("FAIL rr_order[%0d]: got grant=%b g_n=%b owner=%0d want grant=%b owner=%0d",
                     k, grant, g_n, owner, oh, order[k]);
         end
         tick();
         total++;
         if (grant !== oh) begin
            bad++; $display("FAIL rr_hold[%0d]: got grant=%b want %b", k, grant, oh);
         end
         req[order[k]] = 1'b0;
         tick();
         total++;
         if (g_n !== 4'b1111) begin
            bad++; $display("FAIL rr_turn[%0d]: got g_n=%b want 1111", k, g_n);
         end
         req[order[k]] = 1'b1;  // re-raise during TURN: must queue behind others
         tick();
         total++;
         if (g_n !== 4'b1111) begin
            bad++; $display("FAIL rr_idle[%0d]: got g_n=%b want 1111", k, g_n);
         end
         tick();
      end
      req = '0;
   endtask

   task automatic test_timeout();
      do_reset();
      req = 4'b0001;
      tick();
      for (int c = 1; c <= MH; c++) begin
         total++;
         if ({grant, timeout} !== {4'b0001, 1'b0}) begin
            bad++; $display("FAIL tmo_grant_c%0d: got grant=%b tmo=%b want 0001/0", c, grant, timeout);
         end
         if (c == 3) req = 4'b0011;
         tick();
      end
      if (TMO_ON) begin
         total++;
         if ({timeout, g_n} !== {1'b1, 4'b1111}) begin
            bad++; $display("FAIL tmo_pulse: got tmo=%b g_n=%b want 1/1111", timeout, g_n);
         end
         tick();
         total++;
         if ({timeout, g_n} !== {1'b0, 4'b1111}) begin
            bad++; $display("FAIL tmo_gap: got tmo=%b g_n=%b want 0/1111", timeout, g_n);
         end
         tick();
         total++;
         if ({grant, g_n, owner} !== {4'b0010, 4'b1101, 2'd1}) begin
            bad++; $display("FAIL tmo_next: got grant=%b g_n=%b owner=%0d want 0010/1101/1", grant, g_n, owner);
         end
      end else begin
         for (int c = 0; c < 100; c++) begin
            total++;
            if ({g_n, timeout} !== {4'b1110, 1'b0}) begin
               bad++; $display("FAIL notmo_keep_c%0d: got g_n=%b tmo=%b want 1110/0", c, g_n, timeout);
            end
            tick();
         end
      end
      req = '0;
   endtask

   // Reference: owner (-1 = bus free), dead cycles left after a release,
   // round-robin start, cycles held by the current owner.
   task automatic test_random(input int cycles);
      int         own, dead, ptr, hold, pick;
      int         wait_c[4];
      int         hl[4];
      bit         tmo;
      logic [3:0] r, eg;
      int         maxh, bound;
      maxh  = TMO_ON ? MH : 10;
      bound = 4 * (maxh + TC + 1);
      do_reset();
      own = -1; dead = 0; ptr = 0; hold = 0; tmo = 1'b0; r = '0;
      for (int i = 0; i < 4; i++) begin wait_c[i] = 0; hl[i] = 1; end
      for (int cyc = 0; cyc < cycles; cyc++) begin
         @(negedge clk);
         eg = (own >= 0) ? (4'b0001 << own) : 4'b0000;
         total++;
         if ({grant, g_n, busy, timeout} !== {eg, ~eg, own >= 0, tmo}) begin
            bad++;
            $display("FAIL rand_out@%0d: got grant=%b g_n=%b busy=%b tmo=%b want grant=%b tmo=%b",
                     cyc, grant, g_n, busy, timeout, eg, tmo);
         end
         if (own >= 0) begin
            total++;
            if (owner !== 2'(own)) begin
               bad++; $display("FAIL rand_owner@%0d: got %0d want %0d", cyc, owner, own);
            end
         end
         total++;
         if ($countones(~g_n) > 1 || grant !== ~g_n) begin
            bad++; $display("FAIL rand_onehot@%0d: got g_n=%b grant=%b want <=1 low, grant==~g_n", cyc, g_n, grant);
         end
         for (int i = 0; i < 4; i++) begin
            if (eg[i] && hold == 1) begin
               total++;
               if (wait_c[i] > bound) begin
                  bad++; $display("FAIL rand_wait[%0d]: waited %0d want <= %0d", i, wait_c[i], bound);
               end
               wait_c[i] = 0;
            end else if (r[i] && !eg[i]) begin
               wait_c[i]++;
               if (wait_c[i] > bound) begin
                  total++; bad++;
                  $display("FAIL rand_starve[%0d]@%0d: waited %0d want <= %0d", i, cyc, wait_c[i], bound);
                  wait_c[i] = 0;
               end
            end else begin
               wait_c[i] = 0;
            end
         end
         // new stimulus: owners drop after their chosen hold, others keep waiting
         for (int i = 0; i < 4; i++) begin
            if (own == i && r[i] && hold >= hl[i]) r[i] = 1'b0;
            else if (!r[i] && $urandom_range(0, 3) == 0) begin
               r[i]  = 1'b1;
               hl[i] = $urandom_range(1, 10);
            end
         end
         req = r;
         // reference update for the coming edge
         tmo = 1'b0;
         if (own >= 0) begin
            if (!r[own] || (TMO_ON && hold >= MH && (r & ~eg) != 0)) begin
               tmo  = r[own];
               ptr  = (own + 1) % N;
               own  = -1;
               dead = TC;
            end else begin
               hold++;
            end
         end else if (dead > 0) begin
            dead--;
         end else if (r != 0) begin
            pick = -1;
            for (int k = 0; k < N; k++)
               if (pick < 0 && r[(ptr + k) % N]) pick = (ptr + k) % N;
            own  = pick;
            hold = 1;
         end
      end
      req = '0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_all_four();
      test_timeout();
      test_random(10000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
